ex_mem: RTL



---
 rtl/ex_mem_pkg.sv | 42 ++++
 rtl/ex_mem.sv | 96 +++++++++
 2 files changed

// File: rtl/ex_mem_pkg.sv
// Shared widths and constants for the EX/MEM pipeline register.
package ex_mem_pkg;

   localparam int REG_ADDR_W = 5;    // register address bus
   localparam int REG_W      = 32;   // register data bus
   localparam int DREG_W     = 64;   // double-width (HI:LO) bus
   localparam int CNT_W      = 2;    // multiply-accumulate cycle counter

   localparam logic RST_ENABLE    = 1'b0;  // reset is active-low
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;

   localparam logic [REG_W-1:0]      ZERO_WORD    = '0;
   localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

   // Stall vector bit positions
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;

   // Everything handed to the memory-access stage
   typedef struct packed {
      logic [REG_ADDR_W-1:0] wd;
      logic                  wreg;
      logic [REG_W-1:0]      wdata;
      logic [REG_W-1:0]      hi;
      logic [REG_W-1:0]      lo;
      logic                  whilo;
   } mem_stage_t;

   // An empty slot: no destination, no writes
   function automatic mem_stage_t bubble_stage();
      mem_stage_t s;
      s.wd    = NOP_REG_ADDR;
      s.wreg  = WRITE_DISABLE;
      s.wdata = ZERO_WORD;
      s.hi    = ZERO_WORD;
      s.lo    = ZERO_WORD;
      s.whilo = WRITE_DISABLE;
      return s;
   endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register. Captures the execute-stage result, inserts
// bubbles / holds according to the stall vector, and carries the
// multiply-accumulate intermediate (hilo, cnt) back to execute across a
// stall. Optional macro EX_MEM_FLUSH_EN adds a top-priority flush port.
module ex_mem
   import ex_mem_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            stall,
`ifdef EX_MEM_FLUSH_EN
   input  logic                  flush,
`endif
   input  logic [REG_ADDR_W-1:0] ex_wd,
   input  logic                  ex_wreg,
   input  logic [REG_W-1:0]      ex_wdata,
   input  logic [REG_W-1:0]      ex_hi,
   input  logic [REG_W-1:0]      ex_lo,
   input  logic                  ex_whilo,
   input  logic [DREG_W-1:0]     hilo_i,
   input  logic [CNT_W-1:0]      cnt_i,
   output logic [REG_ADDR_W-1:0] mem_wd,
   output logic                  mem_wreg,
   output logic [REG_W-1:0]      mem_wdata,
   output logic [REG_W-1:0]      mem_hi,
   output logic [REG_W-1:0]      mem_lo,
   output logic                  mem_whilo,
   output logic [DREG_W-1:0]     hilo_o,
   output logic [CNT_W-1:0]      cnt_o
);

   mem_stage_t         stage_q, stage_d, ex_stage;
   logic [DREG_W-1:0]  hilo_q, hilo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               flush_req;
   logic               ex_stalled, mem_stalled;
   logic               unused_stall;

`ifdef EX_MEM_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   assign ex_stalled   = stall[STALL_EX];
   assign mem_stalled  = stall[STALL_MEM];
   // Other stages' stall bits do not concern this register
   assign unused_stall = ^{stall[5], stall[2:0]};

   assign ex_stage = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata,
                       hi: ex_hi, lo: ex_lo, whilo: ex_whilo};

   // Next-state selection: flush > bubble(+save) > advance > hold.
   // ex running with mem stalled never occurs; it falls into advance.
   always_comb begin
      stage_d = stage_q;
      hilo_d  = hilo_q;
      cnt_d   = cnt_q;
      if (flush_req) begin
         stage_d = bubble_stage();
         hilo_d  = '0;
         cnt_d   = '0;
      end else if (ex_stalled && !mem_stalled) begin
         stage_d = bubble_stage();
         hilo_d  = hilo_i;
         cnt_d   = cnt_i;
      end else if (!ex_stalled) begin
         stage_d = ex_stage;
         hilo_d  = '0;
         cnt_d   = '0;
      end
   end

   // State registers, cleared asynchronously on reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage_q <= bubble_stage();
         hilo_q  <= '0;
         cnt_q   <= '0;
      end else begin
         stage_q <= stage_d;
         hilo_q  <= hilo_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_wd    = stage_q.wd;
   assign mem_wreg  = stage_q.wreg;
   assign mem_wdata = stage_q.wdata;
   assign mem_hi    = stage_q.hi;
   assign mem_lo    = stage_q.lo;
   assign mem_whilo = stage_q.whilo;
   assign hilo_o    = hilo_q;
   assign cnt_o     = cnt_q;

endmodule
